// File: rtl/pollard_pkg.sv
// rtl/pollard_pkg.sv - shared types and widths for the Pollard p-1 datapath
package pollard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/seq_mod_divider_div_step.sv
// rtl/seq_mod_divider_div_step.sv - one combinational restoring radix-2 divide iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d_ext;
    logic           ge;

    // r can carry its top bit when the divisor is large, so the trial value needs WIDTH+1 bits
    assign t      = {r, q[WIDTH-1]};
    assign d_ext  = {1'b0, d};
    assign ge     = (t >= d_ext);
    assign r_next = WIDTH'(ge ? (t - d_ext) : t);
    assign q_next = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_mod_divider.sv
// rtl/seq_mod_divider.sv - multi-cycle unsigned divider, one quotient bit per clock
module seq_mod_divider
    import pollard_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rfd,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] r_step, q_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + CW'(1);
                // Final step publishes the results from the step outputs, not the registers
                if (cnt_q == LAST) begin
                    quot_d  = q_step;
                    rem_d   = r_step;
                    dbz_d   = (d_q == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign rfd         = (state_q == IDLE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_mod_divider.sv
// tb/tb_seq_mod_divider.sv - directed and random scoreboard bench for seq_mod_divider
module tb_seq_mod_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             rfd;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_by_zero;

    int   errors   = 0;
    int   checks   = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    seq_mod_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .rfd         (rfd),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("done_expected", {63'b0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Entered and left at posedge+1; returns in the done cycle so a following call is back-to-back
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
        int n;
        bit busy_ok;
        check("rfd_before_start", 64'(rfd), 64'd1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        acc_cnt++;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n        = 0;
        busy_ok  = 1'b1;
        while (n < WIDTH + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
            if (rfd !== 1'b0) busy_ok = 1'b0;
            if (poke && n == 10) begin
                start    = 1'b1;
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 64'(n), 64'(WIDTH));
        check("rfd_low_while_busy", 64'(busy_ok), 64'd1);
        check("rfd_in_done_cycle", 64'(rfd), 64'd1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rfd", 64'(rfd), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_quotient", 64'(quotient), 64'd0);
        check("reset_remainder", 64'(remainder), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        #1;
        check("rfd_after_release", 64'(rfd), 64'd1);
        idle(1);

        run_div(32'd100, 32'd7, 1'b0);
        idle(3);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        idle(2);
        run_div(32'd3, 32'd10, 1'b0);
        idle(2);
        run_div(32'd5, 32'd0, 1'b0);
        idle(2);

        // Second request issued in the first one's done cycle, with a stray start mid-run
        run_div(32'd100, 32'd7, 1'b0);
        run_div(32'd1000, 32'd33, 1'b1);
        idle(1);

        // Abort in flight: no done may appear, outputs clear at once
        start    = 1'b1;
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rfd", 64'(rfd), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rfd_after_abort", 64'(rfd), 64'd1);
        idle(WIDTH + 4);
        check("no_done_after_abort", 64'(done_cnt), 64'(acc_cnt));
        run_div(32'h1234_5678, 32'h0000_1000, 1'b0);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 50 == 7) b = '0;
            run_div(a, b, (i % 9) == 3);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(3);

        check("done_count", 64'(done_cnt), 64'(acc_cnt));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
